prio_encoder_rr: RTL
====================

Name: prio_encoder_rr

Overview:
- Parametrised N-to-log2(N) priority encoder with a registered output and a valid/ready handshake on both sides.
- Supports two priority modes, selected per request:
  - fixed priority: highest index wins.
  - round-robin: rotating priority, highest index below the last grant wins first.
- Flags empty and multi-hot requests.
- Sits between request sources and downstream consumers as a one-stage pipelined encoder/arbiter.
- Next generation of the team's 8x3 encoder.

Parameters:
- N, 8, number of request inputs; legal range 2..256.
- W, $clog2(N), output code width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  req/mode are valid this cycle.
- in_ready  output  1  block can accept this cycle.
- req  input  N  request vector; bit i = request from source i.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled with req.
- out_valid  output  1  code/flags hold a result.
- out_ready  input  1  consumer takes the result this cycle.
- code  output  W  index of the winning request.
- out_none  output  1  accepted req was all-zero.
- out_multi  output  1  accepted req had two or more bits set.

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - out_valid=0, code=0, out_none=0, out_multi=0.
  - last-grant pointer last_g=0.
  - in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - out_valid, code, out_none and out_multi update on the clock edge after accept: latency 1 cycle, full throughput.
- Output stability: while out_valid=1 && out_ready=0, all outputs hold stable and no input is accepted.
- Consume without new input: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0 next cycle. code and flags hold their last values.
- Consume with simultaneous accept: in_valid && out_valid && out_ready -> new result loaded, out_valid stays 1.
- Fixed mode (mode=0): code = highest i with req[i]=1.
- Round-robin mode (mode=1):
  - Search order is last_g-1, last_g-2, ..., 0, N-1, ..., last_g (wraps).
  - With last_g=0, the order starts at N-1, so the first RR grant after reset matches fixed priority.
- Pointer update:
  - last_g <= code on every accept with req!=0, in both modes.
  - A mode switch does not reset last_g.
- req=0 on accept: out_none=1, out_multi=0, code=0, last_g unchanged.
- out_multi = popcount(req)>=2, computed on the accepted vector.
- Reset asserted mid-operation: any pending result is dropped, outputs and last_g are cleared immediately (async), and there is no residual grant.
- Implementation structure:
  - RR uses a masked search (req bits below last_g); if the masked vector is empty, fall back to an unmasked search.
  - Both searches are highest-index-wins.

Decomposition:
- Shared package/include holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - A CLOG2-safe width helper for N.
- Sub-module prio_pick (parameter N): purely combinational highest-set-bit finder.
  - Outputs: idx[W-1:0] and any.
  - Instantiated twice: masked and unmasked vectors.
- The top module holds the pointer, the output register and the handshake.

Test Plan (N=8):
- Fixed mode: accept req=8'b01011011 -> next cycle out_valid=1, code=6, out_multi=1, out_none=0.
- Fixed mode: req=8'b00000001 -> code=0, multi=0. Then req=8'b00000111 -> code=2, multi=1.
- Empty request: req=8'h00 accepted -> out_none=1, code=0. A following RR req=8'hFF still yields code=7 (pointer unchanged from reset).
- RR fairness: mode=1, req=8'hFF held, in_valid=1 and out_ready=1 for 10 cycles -> codes 7,6,5,4,3,2,1,0,7,6 on consecutive cycles. Then req=8'b00100100 after grant 6 -> code=5, then 2, then 5.
- Backpressure: out_ready=0 with a result held -> in_ready=0, code/flags stable for 5 cycles, new req ignored. out_ready=1 with in_valid=1 in the same cycle -> new result next cycle, out_valid never drops.
- Reset mid-stream: rst_n low while out_valid=1 in RR mode after grant 3 -> out_valid=0 and code=0 immediately (before the next edge). After release, req=8'hFF RR -> code=7.

Source files
------------

// File: rtl/prio_encoder_rr_pkg.sv
// Shared constants and width helper for the round-robin priority encoder.
package prio_encoder_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Code width that never collapses to zero for tiny N.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// Combinational highest-set-bit finder; idx is 0 when no bit is set.
module prio_pick
  import prio_encoder_rr_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = clog2_safe(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/prio_encoder_rr.sv
// One-stage pipelined priority encoder/arbiter with fixed and round-robin modes
// and valid/ready handshakes on both sides.
module prio_encoder_rr
  import prio_encoder_rr_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = clog2_safe(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] code,
  output logic         out_none,
  output logic         out_multi
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] code_q, code_d;
  logic         none_q, none_d;
  logic         multi_q, multi_d;
  logic [W-1:0] last_g_q, last_g_d;

  logic [N-1:0] masked;
  logic [W-1:0] m_idx, u_idx, pick;
  logic         m_any, u_any, accept;

  // Requests strictly below the last grant get first chance in RR mode.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < N; i++) begin
      masked[i] = req[i] & (W'(i) < last_g_q);
    end
  end

  prio_pick #(.N(N)) u_pick_masked (
    .vec (masked),
    .idx (m_idx),
    .any (m_any)
  );

  prio_pick #(.N(N)) u_pick_full (
    .vec (req),
    .idx (u_idx),
    .any (u_any)
  );

  assign pick     = (mode == MODE_RR && m_any) ? m_idx : u_idx;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state: load on accept, drop valid on a bare consume, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    code_d      = code_q;
    none_d      = none_q;
    multi_d     = multi_q;
    last_g_d    = last_g_q;
    if (accept) begin
      out_valid_d = 1'b1;
      code_d      = pick;
      none_d      = !u_any;
      multi_d     = |(req & (req - N'(1)));
      if (u_any) last_g_d = pick;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      code_q      <= '0;
      none_q      <= 1'b0;
      multi_q     <= 1'b0;
      last_g_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      none_q      <= none_d;
      multi_q     <= multi_d;
      last_g_q    <= last_g_d;
    end
  end

  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign out_none  = none_q;
  assign out_multi = multi_q;

endmodule
